qam_sym_mapper: RTL and testbench

Parametrised M-QAM symbol mapper that replaces the fixed 4-bit 16-QAM input path in front of the modulator. It accepts a byte-wide framed data stream and regroups it into 2/4/6-bit symbols (QPSK/16-QAM/64-QAM) through a gearbox. Each symbol is Gray-mapped to signed odd-integer I/Q levels and driven out on a valid/ready stream with full backpressure. The mode is selectable per frame at run time.

---
 rtl/qam_sym_mapper.sv | 146 ++++++++++++++
 tb/tb_qam_sym_mapper.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/qam_sym_mapper.sv
// M-QAM symbol mapper: byte stream -> gearbox -> Gray-coded I/Q levels on a valid/ready stream.
// Optional symbol counter port sym_cnt enabled by defining QAM_SYM_CNT_EN.
module qam_sym_mapper #(
  parameter int DIN_W   = 8,
  parameter int MAX_BPS = 6,
  parameter int OUT_W   = 8
) (
  input  logic                    axi_clk,
  input  logic                    axi_rstn,
  input  logic [1:0]              mode,
  input  logic                    din_valid,
  input  logic [DIN_W-1:0]        din,
  input  logic                    din_last,
  output logic                    din_ready,
  output logic                    dout_valid,
  output logic signed [OUT_W-1:0] dout_i,
  output logic signed [OUT_W-1:0] dout_q,
  output logic                    dout_last,
`ifdef QAM_SYM_CNT_EN
  output logic [15:0]             sym_cnt,
`endif
  input  logic                    dout_ready
);

  localparam int BUF_W = DIN_W + MAX_BPS - 1;
  localparam int CW    = $clog2(BUF_W + 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t             state_q, state_d;
  logic [BUF_W-1:0]   sbuf_q, sbuf_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2:0]         bps_q;
  logic               ready_en_q;

  logic [CW-1:0]      bps_c, pop_amt, cnt_rem;
  logic               have_full, residue, out_free, pop, load, pop_last;
  logic [MAX_BPS-1:0] top;
  logic [2:0]         g_i, g_q;
  logic [1:0]         k;

  // Gray -> binary per axis, then 2b-(2^k-1); modular arithmetic yields the sign extension.
  function automatic logic [OUT_W-1:0] level(input logic [2:0] g, input logic [1:0] kk);
    logic [2:0] b;
    b[2] = g[2];
    b[1] = g[1] ^ b[2];
    b[0] = g[0] ^ b[1];
    return OUT_W'({b, 1'b0}) - OUT_W'((4'd1 << kk) - 4'd1);
  endfunction

  always_comb begin
    bps_c     = CW'(bps_q);
    have_full = (cnt_q != '0) && (cnt_q >= bps_c);
    residue   = (state_q == FLUSH) && (cnt_q != '0);
    out_free  = !dout_valid || dout_ready;
    pop       = out_free && (have_full || residue);
    pop_amt   = have_full ? bps_c : cnt_q;
    cnt_rem   = pop ? cnt_q - pop_amt : cnt_q;
    din_ready = ready_en_q && (state_q != FLUSH) && (cnt_rem <= CW'(BUF_W - DIN_W));
    load      = din_valid && din_ready;
    pop_last  = pop && (state_q == FLUSH) && (cnt_rem == '0);
    // New beat lands directly below the bits that survive this cycle's pop.
    sbuf_d    = (pop ? sbuf_q << pop_amt : sbuf_q)
              | (load ? ({din, {(BUF_W-DIN_W){1'b0}}} >> cnt_rem) : '0);
    cnt_d     = load ? cnt_rem + CW'(DIN_W) : cnt_rem;
  end

  always_comb begin
    top = sbuf_q[BUF_W-1 -: MAX_BPS];
    k   = bps_q[2:1];
    case (bps_q)
      3'd2: begin
        g_i = {2'b00, top[MAX_BPS-1]};
        g_q = {2'b00, top[MAX_BPS-2]};
      end
      3'd6: begin
        g_i = top[MAX_BPS-1 -: 3];
        g_q = top[MAX_BPS-4 -: 3];
      end
      default: begin
        g_i = {1'b0, top[MAX_BPS-1 -: 2]};
        g_q = {1'b0, top[MAX_BPS-3 -: 2]};
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load) state_d = din_last ? FLUSH : RUN;
      RUN:     if (load && din_last) state_d = FLUSH;
      FLUSH:   if (dout_valid && dout_ready && dout_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      state_q    <= IDLE;
      sbuf_q     <= '0;
      cnt_q      <= '0;
      bps_q      <= 3'd4;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sbuf_q     <= sbuf_d;
      cnt_q      <= cnt_d;
      ready_en_q <= 1'b1;
      if (state_q == IDLE && load) begin
        case (mode)
          2'd0:    bps_q <= 3'd2;
          2'd2:    bps_q <= 3'd6;
          default: bps_q <= 3'd4;
        endcase
      end
    end
  end

  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      dout_valid <= 1'b0;
      dout_i     <= '0;
      dout_q     <= '0;
      dout_last  <= 1'b0;
    end else if (pop) begin
      dout_valid <= 1'b1;
      dout_i     <= level(g_i, k);
      dout_q     <= level(g_q, k);
      dout_last  <= pop_last;
    end else if (dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

`ifdef QAM_SYM_CNT_EN
  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      sym_cnt <= '0;
    end else if (dout_valid && dout_ready) begin
      if (dout_last)             sym_cnt <= '0;
      else if (sym_cnt != '1)    sym_cnt <= sym_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_qam_sym_mapper.sv
// Self-checking bench for qam_sym_mapper: bit-queue reference model plus literal symbol tables.
module tb_qam_sym_mapper;

  logic              axi_clk = 1'b0;
  logic              axi_rstn = 1'b0;
  logic [1:0]        mode = 2'd1;
  logic              din_valid = 1'b0;
  logic [7:0]        din = '0;
  logic              din_last = 1'b0;
  logic              din_ready;
  logic              dout_valid;
  logic signed [7:0] dout_i, dout_q;
  logic              dout_last;
  logic              dout_ready = 1'b1;
`ifdef QAM_SYM_CNT_EN
  logic [15:0]       sym_cnt;
  int                m_cnt = 0;
`endif

  qam_sym_mapper #(.DIN_W(8), .MAX_BPS(6), .OUT_W(8)) dut (
    .axi_clk(axi_clk), .axi_rstn(axi_rstn), .mode(mode),
    .din_valid(din_valid), .din(din), .din_last(din_last), .din_ready(din_ready),
    .dout_valid(dout_valid), .dout_i(dout_i), .dout_q(dout_q), .dout_last(dout_last),
`ifdef QAM_SYM_CNT_EN
    .sym_cnt(sym_cnt),
`endif
    .dout_ready(dout_ready)
  );

  always #5 axi_clk = ~axi_clk;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  always @(posedge axi_clk) cyc++;

  // reference model state
  bit          bitq[$];
  int          m_bps = 4;
  bit          m_done = 0, in_frame = 0;
  int          frame_cyc = 0, first_valid_cyc = -1;
  logic [16:0] got[$];
  logic [16:0] exp_q[$];
  logic [7:0]  bq[$];
  bit          pv = 0, pr = 0;
  logic [17:0] prev = '0;
  int          n, s, kk, ei, eq;
  bit          el;
  logic [7:0]  ei8, eq8;

  function automatic int lvl(input int g, input int k);
    int b = g;
    for (int sh = 1; sh < k; sh++) b = b ^ (g >> sh);
    return 2 * b - ((1 << k) - 1);
  endfunction

  function automatic logic [16:0] sy(input int i, input int q, input bit l);
    logic [7:0] a, b;
    a = i[7:0];
    b = q[7:0];
    return {l, a, b};
  endfunction

  always @(negedge axi_clk) if (axi_rstn) begin
    if (pv && !pr) begin
      n_cmp++;
      if ({dout_valid, dout_i, dout_q, dout_last} != prev) begin
        n_bad++;
        $display("FAIL hold: got %h required %h", {dout_valid, dout_i, dout_q, dout_last}, prev);
      end
    end
    if (dout_valid && !pv && first_valid_cyc < 0) first_valid_cyc = cyc;
`ifdef QAM_SYM_CNT_EN
    n_cmp++;
    if (sym_cnt != m_cnt[15:0]) begin
      n_bad++;
      $display("FAIL sym_cnt: got %0d required %0d", sym_cnt, m_cnt);
    end
`endif
    if (dout_valid && dout_ready) begin
      got.push_back({dout_last, dout_i, dout_q});
      n_cmp++;
      if (bitq.size() == 0 || (bitq.size() < m_bps && !m_done)) begin
        n_bad++;
        $display("FAIL symbol: got (%0d,%0d,%0b) required none", dout_i, dout_q, dout_last);
      end else begin
        n = (bitq.size() < m_bps) ? bitq.size() : m_bps;
        s = 0;
        for (int j = 0; j < m_bps; j++) s = (s << 1) | ((j < n) ? int'(bitq.pop_front()) : 0);
        kk = m_bps / 2;
        ei = lvl(s >> kk, kk);
        eq = lvl(s & ((1 << kk) - 1), kk);
        el = m_done && (bitq.size() == 0);
        ei8 = ei[7:0];
        eq8 = eq[7:0];
        if (dout_i != ei8 || dout_q != eq8 || dout_last != el) begin
          n_bad++;
          $display("FAIL symbol: got (%0d,%0d,%0b) required (%0d,%0d,%0b)",
                   dout_i, dout_q, dout_last, ei, eq, el);
        end
        if (el) begin m_done = 0; in_frame = 0; end
      end
`ifdef QAM_SYM_CNT_EN
      if (dout_last) m_cnt = 0;
      else if (m_cnt < 65535) m_cnt++;
`endif
    end
    pv = dout_valid;
    pr = dout_ready;
    prev = {dout_valid, dout_i, dout_q, dout_last};
    if (din_valid && din_ready) begin
      if (!in_frame) begin
        in_frame = 1;
        m_bps = (mode == 2'd0) ? 2 : (mode == 2'd2) ? 6 : 4;
        frame_cyc = cyc;
      end
      for (int j = 7; j >= 0; j--) bitq.push_back(din[j]);
      if (din_last) m_done = 1;
    end
  end

  task automatic chk(input string name, input int got_v, input int req_v);
    n_cmp++;
    if (got_v != req_v) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, got_v, req_v);
    end
  endtask

  task automatic send_beat(input logic [7:0] d, input bit l);
    bit ok = 0;
    din = d; din_last = l; din_valid = 1'b1;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge axi_clk);
      ok = din_ready;
      @(posedge axi_clk); #1;
    end
    din_valid = 1'b0; din_last = 1'b0;
    chk("beat_accept", int'(ok), 1);
  endtask

  task automatic drain();
    bit done = 0;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge axi_clk); #1;
      done = !dout_valid && (bitq.size() == 0) && din_ready;
    end
    chk("drain_idle_ready", int'(done), 1);
    @(posedge axi_clk); #1;
  endtask

  task automatic check_log();
    chk("log_len", got.size(), exp_q.size());
    foreach (exp_q[i]) begin
      n_cmp++;
      if (i >= got.size() || got[i] != exp_q[i]) begin
        n_bad++;
        $display("FAIL log[%0d]: got %h required %h", i, (i < got.size()) ? got[i] : 17'h0, exp_q[i]);
      end
    end
    got.delete();
    exp_q.delete();
  endtask

  task automatic ex(input int i, input int q, input bit l);
    exp_q.push_back(sy(i, q, l));
  endtask

  task automatic frame(input logic [1:0] md);
    mode = md;
    foreach (bq[i]) send_beat(bq[i], i == bq.size() - 1);
    bq.delete();
    drain();
    check_log();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

  initial begin
    chk("model_lvl16", lvl(2, 2), 3);
    chk("model_lvl64", lvl(7, 3), 3);
    chk("model_lvl64b", lvl(4, 3), 7);

    repeat (3) @(posedge axi_clk); #1;
    chk("reset_outs", int'({din_ready, dout_valid, dout_i, dout_q, dout_last}), 0);
    axi_rstn = 1'b1; #1;
    chk("ready_after_release", int'(din_ready), 0);
    @(posedge axi_clk); #1;
    chk("ready_first_cycle", int'(din_ready), 1);

    // 16-QAM single beat, latency 2
    first_valid_cyc = -1;
    bq.push_back(8'hB4);
    ex(3, 1, 0); ex(-1, -3, 1);
    frame(2'd1);
    chk("latency", first_valid_cyc - frame_cyc, 2);

    // QPSK
    bq.push_back(8'h1B);
    ex(-1, -1, 0); ex(-1, 1, 0); ex(1, -1, 0); ex(1, 1, 1);
    frame(2'd0);

    // 64-QAM, 24 bits, no padding
    bq.push_back(8'hFF); bq.push_back(8'h00); bq.push_back(8'hFF);
    ex(3, 3, 0); ex(1, -7, 0); ex(-7, -3, 0); ex(3, 3, 1);
    frame(2'd2);

    // 64-QAM residue padded
    bq.push_back(8'hFF);
    ex(3, 3, 0); ex(1, -7, 1);
    frame(2'd2);

    // backpressure with mode toggle mid-frame
    mode = 2'd1;
    fork
      begin
        send_beat(8'hA5, 0); send_beat(8'h3C, 0);
        send_beat(8'h0F, 0); send_beat(8'hF0, 1);
      end
      begin
        dout_ready = 1'b0;
        repeat (2) @(posedge axi_clk); #1;
        mode = 2'd0;
        repeat (8) @(posedge axi_clk);
        @(negedge axi_clk);
        chk("stall_ready_low", int'(din_ready), 0);
        @(posedge axi_clk); #1;
        dout_ready = 1'b1;
      end
    join
    drain();
    ex(3, 3, 0); ex(-1, -1, 0); ex(-3, 1, 0); ex(1, -3, 0);
    ex(-3, -3, 0); ex(1, 1, 0); ex(1, 1, 0); ex(-3, -3, 1);
    check_log();

    // reset mid-frame
    mode = 2'd1;
    dout_ready = 1'b0;
    send_beat(8'hA5, 0);
    repeat (3) @(posedge axi_clk);
    chk("pre_reset_valid", int'(dout_valid), 1);
    #3 axi_rstn = 1'b0;
    #1;
    chk("async_reset_outs", int'({din_ready, dout_valid, dout_i, dout_q, dout_last}), 0);
    bitq.delete(); got.delete(); in_frame = 0; m_done = 0; pv = 0; pr = 0;
`ifdef QAM_SYM_CNT_EN
    m_cnt = 0;
`endif
    @(posedge axi_clk); #1;
    axi_rstn = 1'b1;
    @(posedge axi_clk); #1;
    dout_ready = 1'b1;
    bq.push_back(8'h00);
    ex(-1, -1, 0); ex(-1, -1, 0); ex(-1, -1, 0); ex(-1, -1, 1);
    frame(2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
